// File: rtl/systolic_fpga_example_sched_pkg.sv
// Shared types and helpers for the burst scheduler: FSM state encoding and
// 4 KiB page arithmetic used to keep every burst inside one page.
package systolic_fpga_example_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int unsigned LP_4K_BYTES = 4096;

    // Beats left before the next 4 KiB page, for a beat-aligned page offset.
    function automatic logic [12:0] beats_to_boundary(input logic [11:0]  offs,
                                                      input int unsigned beat_shift);
        return (13'(LP_4K_BYTES) - {1'b0, offs}) >> beat_shift;
    endfunction

endpackage

// File: rtl/systolic_fpga_example_outstanding_ctr.sv
// Saturating up/down counter of issued-but-uncompleted bursts; flags an
// attempted decrement from zero.
module systolic_fpga_example_outstanding_ctr
    import systolic_fpga_example_sched_pkg::*;
#(
    parameter int unsigned C_MAX = 16,
    parameter int unsigned C_W   = $clog2(C_MAX + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           incr,
    input  logic           decr,
    output logic [C_W-1:0] count,
    output logic           is_zero,
    output logic           is_full,
    output logic           underflow
);

    assign is_zero   = (count == '0);
    assign is_full   = (count == C_W'(C_MAX));
    assign underflow = decr & is_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (incr && !decr && !is_full) begin
            count <= count + 1'b1;
        end else if (decr && !incr && !is_zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/systolic_fpga_example_burst_scheduler.sv
// Splits one transfer command into AXI-legal bursts (max length, no 4 KiB
// crossing) and throttles issue by the number of bursts still in flight.
module systolic_fpga_example_burst_scheduler
    import systolic_fpga_example_sched_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_LEN_WIDTH       = 32,
    parameter int unsigned C_BEAT_BYTES      = 64,
    parameter int unsigned C_MAX_BURST       = 32,
    parameter int unsigned C_MAX_OUTSTANDING = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [C_ADDR_WIDTH-1:0]                  base_addr,
    input  logic [C_LEN_WIDTH-1:0]                   total_beats,
    output logic                                     req_valid,
    input  logic                                     req_ready,
    output logic [C_ADDR_WIDTH-1:0]                  req_addr,
    output logic [7:0]                               req_len,
    input  logic                                     cmpl,
    output logic                                     busy,
    output logic                                     done,
    output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                     err_underflow
);

    localparam int unsigned LP_CW         = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int unsigned LP_BEAT_SHIFT = $clog2(C_BEAT_BYTES);
    localparam logic [C_ADDR_WIDTH-1:0] LP_ALIGN_MASK = ~C_ADDR_WIDTH'(C_BEAT_BYTES - 1);

    sched_state_t            state;
    logic [C_LEN_WIDTH-1:0]  remaining;
    logic                    hs;
    logic                    ctr_zero;
    logic                    ctr_full;
    logic                    ctr_underflow;
    logic [LP_CW-1:0]        out_next;
    logic [8:0]              cur_beats;
    logic [8:0]              next_beats;
    logic [8:0]              start_beats;
    logic [C_ADDR_WIDTH-1:0] next_addr;
    logic [C_ADDR_WIDTH-1:0] start_addr;
    logic [C_LEN_WIDTH-1:0]  next_rem;

    function automatic logic [8:0] burst_beats(input logic [C_ADDR_WIDTH-1:0] addr,
                                               input logic [C_LEN_WIDTH-1:0]  rem);
        logic [12:0] to_4k;
        logic [8:0]  beats;
        to_4k = beats_to_boundary(addr[11:0], LP_BEAT_SHIFT);
        beats = 9'(C_MAX_BURST);
        if (to_4k < 13'(beats)) beats = to_4k[8:0];
        if (rem < C_LEN_WIDTH'(beats)) beats = rem[8:0];
        return beats;
    endfunction

    systolic_fpga_example_outstanding_ctr #(
        .C_MAX (C_MAX_OUTSTANDING),
        .C_W   (LP_CW)
    ) u_outstanding_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .incr      (hs),
        .decr      (cmpl),
        .count     (outstanding),
        .is_zero   (ctr_zero),
        .is_full   (ctr_full),
        .underflow (ctr_underflow)
    );

    // req_valid is registered, so it is decided from the count the
    // counter will hold after this edge rather than its current value.
    always_comb begin
        hs          = req_valid & req_ready;
        cur_beats   = {1'b0, req_len} + 9'd1;
        next_addr   = req_addr + (C_ADDR_WIDTH'(cur_beats) << LP_BEAT_SHIFT);
        next_rem    = remaining - C_LEN_WIDTH'(cur_beats);
        next_beats  = burst_beats(next_addr, next_rem);
        start_addr  = base_addr & LP_ALIGN_MASK;
        start_beats = burst_beats(start_addr, total_beats);
        out_next    = outstanding;
        if (hs && !cmpl && !ctr_full) begin
            out_next = outstanding + 1'b1;
        end else if (cmpl && !hs && !ctr_zero) begin
            out_next = outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            remaining     <= '0;
            req_valid     <= 1'b0;
            req_addr      <= '0;
            req_len       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            done          <= 1'b0;
            err_underflow <= err_underflow | ctr_underflow;
            case (state)
                IDLE: begin
                    if (start && total_beats != '0) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        req_addr  <= start_addr;
                        req_len   <= 8'(start_beats - 9'd1);
                        remaining <= total_beats;
                        req_valid <= (out_next < LP_CW'(C_MAX_OUTSTANDING));
                    end else if (start) begin
                        state <= DONE;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (hs && next_rem == '0) begin
                        state     <= DRAIN;
                        req_valid <= 1'b0;
                        remaining <= '0;
                    end else begin
                        if (hs) begin
                            req_addr  <= next_addr;
                            req_len   <= 8'(next_beats - 9'd1);
                            remaining <= next_rem;
                        end
                        req_valid <= (out_next < LP_CW'(C_MAX_OUTSTANDING));
                    end
                end
                DRAIN: begin
                    if (out_next == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_fpga_example_burst_scheduler.sv
// Self-checking bench for the burst scheduler: table vectors, directed
// corner sequences and randomized commands against a burst-list model.
module tb_systolic_fpga_example_burst_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] base_addr;
    logic [31:0] total_beats;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic        cmpl;
    logic        busy;
    logic        done;
    logic [4:0]  outstanding;
    logic        err_underflow;

    systolic_fpga_example_burst_scheduler #(
        .C_ADDR_WIDTH      (64),
        .C_LEN_WIDTH       (32),
        .C_BEAT_BYTES      (64),
        .C_MAX_BURST       (32),
        .C_MAX_OUTSTANDING (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .total_beats   (total_beats),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .cmpl          (cmpl),
        .busy          (busy),
        .done          (done),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } burst_t;

    typedef struct {
        logic [63:0] base;
        logic [31:0] total;
        int unsigned n;
        logic [63:0] f_addr;
        logic [7:0]  f_len;
        logic [63:0] l_addr;
        logic [7:0]  l_len;
    } vec_t;

    burst_t      exp_q[$];
    vec_t        vecs[6];
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned model_out = 0;
    bit          model_err = 0;
    int unsigned hs_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned burst_n = 0;
    logic [63:0] f_addr, l_addr;
    logic [7:0]  f_len, l_len;
    bit          pend = 0;
    logic [63:0] pend_addr;
    logic [7:0]  pend_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected burst list from the splitting rules, computed up front.
    task automatic start_cmd(input logic [63:0] base, input logic [31:0] total);
        logic [63:0] a;
        logic [31:0] r;
        int unsigned b, room;
        burst_t      bt;
        exp_q.delete();
        a = base & ~64'd63;
        r = total;
        while (r != 0) begin
            room = (32'd4096 - 32'(a[11:0])) / 32'd64;
            b = 32;
            if (room < b) b = room;
            if (r < b) b = r;
            bt.addr = a;
            bt.len  = 8'(b - 1);
            exp_q.push_back(bt);
            a = a + 64'(b * 64);
            r = r - b;
        end
        burst_n     = 0;
        pend        = 0;
        start       = 1'b1;
        base_addr   = base;
        total_beats = total;
        req_ready   = 1'b0;
        cmpl        = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic step(input bit rdy, input bit cm);
        bit          take;
        int unsigned pre;
        req_ready = rdy;
        cmpl      = cm;
        take      = req_valid && rdy;
        if (model_out >= 16) chk("valid_when_full", 64'(req_valid), 0);
        if (exp_q.size() == 0) chk("valid_no_work", 64'(req_valid), 0);
        if (take && exp_q.size() != 0) begin
            chk("req_addr", req_addr, exp_q[0].addr);
            chk("req_len", 64'(req_len), 64'(exp_q[0].len));
            if (burst_n == 0) begin
                f_addr = req_addr;
                f_len  = req_len;
            end
            l_addr = req_addr;
            l_len  = req_len;
            burst_n++;
            hs_cnt++;
            void'(exp_q.pop_front());
        end
        pend      = req_valid && !rdy;
        pend_addr = req_addr;
        pend_len  = req_len;
        pre       = model_out;
        if (take && !cm) model_out++;
        else if (cm && !take && pre > 0) model_out--;
        if (cm && pre == 0) model_err = 1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        cmpl      = 1'b0;
        chk("outstanding", 64'(outstanding), 64'(model_out));
        chk("err_underflow", 64'(err_underflow), 64'(model_err));
        if (pend) begin
            chk("hold_valid", 64'(req_valid), 1);
            chk("hold_addr", req_addr, pend_addr);
            chk("hold_len", 64'(req_len), 64'(pend_len));
        end
        if (done) done_cnt++;
    endtask

    task automatic run_loop(input int unsigned rdy_pct, input int unsigned cmpl_pct,
                            input int unsigned budget);
        int unsigned n = 0;
        bit          r, c;
        while (!done && n < budget) begin
            r = ($urandom_range(1, 100) <= rdy_pct);
            c = (model_out > 0) && ($urandom_range(1, 100) <= cmpl_pct);
            step(r, c);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        end else begin
            chk("done_queue_empty", 64'(exp_q.size()), 0);
            chk("done_outstanding", 64'(outstanding), 0);
            chk("done_busy", 64'(busy), 1);
            step(1'b0, 1'b0);
            chk("done_width", 64'(done), 0);
            chk("idle_busy", 64'(busy), 0);
        end
    endtask

    initial begin
        logic [63:0] a0;
        logic [7:0]  l0;
        logic [63:0] rb;
        int unsigned h0, dc;

        vecs[0] = '{64'h0,    32'd100, 4, 64'h0,    8'd31, 64'h1800, 8'd3};
        vecs[1] = '{64'hF80,  32'd10,  2, 64'hF80,  8'd1,  64'h1000, 8'd7};
        vecs[2] = '{64'h1005, 32'd1,   1, 64'h1000, 8'd0,  64'h1000, 8'd0};
        vecs[3] = '{64'hFC0,  32'd40,  3, 64'hFC0,  8'd0,  64'h1800, 8'd6};
        vecs[4] = '{64'h3F00, 32'd64,  3, 64'h3F00, 8'd3,  64'h4800, 8'd27};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC0, 32'd3, 2,
                    64'hFFFF_FFFF_FFFF_FFC0, 8'd0, 64'h0, 8'd1};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; total_beats = '0;
        req_ready = 1'b0; cmpl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(req_valid), 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_len", 64'(req_len), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_out", 64'(outstanding), 0);
        chk("rst_err", 64'(err_underflow), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            start_cmd(vecs[i].base, vecs[i].total);
            run_loop(100, 50, 2000);
            chk("vec_nbursts", 64'(burst_n), 64'(vecs[i].n));
            chk("vec_first_addr", f_addr, vecs[i].f_addr);
            chk("vec_first_len", 64'(f_len), 64'(vecs[i].f_len));
            chk("vec_last_addr", l_addr, vecs[i].l_addr);
            chk("vec_last_len", 64'(l_len), 64'(vecs[i].l_len));
        end

        // Done must follow the final completion by exactly one cycle.
        start_cmd(64'h0, 32'd100);
        for (int i = 0; i < 4; i++) begin
            chk("a_valid", 64'(req_valid), 1);
            step(1'b1, 1'b0);
        end
        chk("a_valid_drop", 64'(req_valid), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("a_no_early_done", 64'(done), 0);
        end
        step(1'b0, 1'b1);
        chk("a_done", 64'(done), 1);
        chk("a_busy_in_done", 64'(busy), 1);
        step(1'b0, 1'b0);
        chk("a_done_width", 64'(done), 0);
        chk("a_busy_after", 64'(busy), 0);

        // Outstanding limit, single-slot refill, hold and same-cycle update.
        start_cmd(64'h0, 32'd640);
        h0 = hs_cnt;
        repeat (20) step(1'b1, 1'b0);
        chk("b_full_hs", 64'(hs_cnt - h0), 16);
        chk("b_full_valid", 64'(req_valid), 0);
        chk("b_full_out", 64'(outstanding), 16);
        step(1'b1, 1'b1);
        h0 = hs_cnt;
        repeat (4) step(1'b1, 1'b0);
        chk("b_one_more", 64'(hs_cnt - h0), 1);
        repeat (11) step(1'b0, 1'b1);
        chk("b_out5", 64'(outstanding), 5);
        chk("b_valid5", 64'(req_valid), 1);
        a0 = req_addr;
        l0 = req_len;
        repeat (3) step(1'b0, 1'b0);
        chk("b_stable_addr", req_addr, a0);
        chk("b_stable_len", 64'(req_len), 64'(l0));
        step(1'b1, 1'b1);
        chk("b_same_cycle", 64'(outstanding), 5);
        run_loop(100, 100, 500);

        start_cmd(64'h1234, 32'd0);
        chk("z_done", 64'(done), 1);
        chk("z_valid", 64'(req_valid), 0);
        chk("z_busy", 64'(busy), 1);
        step(1'b0, 1'b0);
        chk("z_done_width", 64'(done), 0);
        chk("z_busy_after", 64'(busy), 0);

        chk("u_err_before", 64'(err_underflow), 0);
        step(1'b0, 1'b1);
        chk("u_err_set", 64'(err_underflow), 1);
        repeat (3) step(1'b0, 1'b0);
        chk("u_err_sticky", 64'(err_underflow), 1);
        chk("u_out_zero", 64'(outstanding), 0);

        for (int i = 0; i < 15; i++) begin
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1)
                rb[11:0] = 12'(4096 - 64 * $urandom_range(1, 4));
            start_cmd(rb, 32'($urandom_range(0, 200)));
            run_loop($urandom_range(30, 100), $urandom_range(20, 90), 3000);
        end

        // Asynchronous reset in the middle of a command.
        start_cmd(64'h0, 32'd640);
        repeat (7) step(1'b1, 1'b0);
        chk("r_out7", 64'(outstanding), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_valid", 64'(req_valid), 0);
        chk("r_addr", req_addr, 0);
        chk("r_len", 64'(req_len), 0);
        chk("r_busy", 64'(busy), 0);
        chk("r_done", 64'(done), 0);
        chk("r_out", 64'(outstanding), 0);
        chk("r_err", 64'(err_underflow), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        model_out = 0;
        model_err = 0;
        pend = 0;
        dc = done_cnt;
        repeat (3) step(1'b0, 1'b0);
        chk("r_no_done", 64'(done_cnt - dc), 0);
        start_cmd(64'h2000, 32'd50);
        run_loop(100, 60, 1000);
        chk("r_restart_bursts", 64'(burst_n), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
